// File: rtl/lea_reg_load_ctrl.sv
// lea_reg_load_ctrl
// Byte-wise load/unload sequencer for the LEA 128-bit state register bank.
// Accepts NBYTES bytes over a valid/ready stream and steers each one into the
// next bank register through a one-hot clock-enable. It then pulses the round
// core, waits for completion, and streams the result bytes back out by stepping
// the bank read-mux select.
//
// Build option:
//   LEA_CTRL_REVERSE_EN  when defined, byte k maps to register NBYTES-1-k for
//                        both loading and unloading. Otherwise byte k maps to
//                        register k.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clear      synchronous abort to IDLE
//   in_valid   input byte valid
//   in_ready   controller can accept a byte (IDLE/LOAD)
//   in_data    input byte
//   reg_din    data to all bank register Din pins (in_data, combinational)
//   reg_ce     one-hot bank register clock-enable (combinational)
//   start      one-cycle start pulse to the round core
//   done       core completion, only looked at in WAIT
//   out_valid  result byte available at the bank read mux
//   out_ready  consumer accepts the result byte
//   out_sel    bank read-mux select
//   busy       high in START, WAIT and UNLOAD
//
// state  | meaning
// IDLE   | no operation in progress, waiting for the first byte
// LOAD   | bytes being written into the bank
// START  | single-cycle start pulse to the core
// WAIT   | core running, waiting for done
// UNLOAD | result bytes presented on the read mux
module lea_reg_load_ctrl #(
    parameter int NBYTES = 16,
    parameter int IW     = $clog2(NBYTES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    output logic [7:0]        reg_din,
    output logic [NBYTES-1:0] reg_ce,
    output logic              start,
    input  logic              done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IW-1:0]     out_sel,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_UNLOAD
    } state_t;

    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    state_t        state, state_nxt;
    logic [IW-1:0] cnt, cnt_nxt;
    logic          accept;
    logic          xfer;
    logic          start_q, out_valid_q, busy_q;
    logic [IW-1:0] out_sel_q;

    function automatic logic [IW-1:0] map_idx(input logic [IW-1:0] k);
`ifdef LEA_CTRL_REVERSE_EN
        return LAST - k;
`else
        return k;
`endif
    endfunction

    assign in_ready = (state == S_IDLE) || (state == S_LOAD);
    // A byte arriving together with clear is dropped: no write, no count.
    assign accept   = in_valid && in_ready && !clear;
    assign xfer     = (state == S_UNLOAD) && out_valid_q && out_ready;
    assign reg_din  = in_data;
    assign reg_ce   = accept ? (NBYTES'(1) << map_idx(cnt)) : '0;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (clear) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                S_IDLE, S_LOAD: begin
                    if (accept) begin
                        if (cnt == LAST) begin
                            state_nxt = S_START;
                            cnt_nxt   = '0;
                        end else begin
                            state_nxt = S_LOAD;
                            cnt_nxt   = cnt + IW'(1);
                        end
                    end
                end
                S_START: begin
                    state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    if (done) begin
                        state_nxt = S_UNLOAD;
                        cnt_nxt   = '0;
                    end
                end
                S_UNLOAD: begin
                    if (xfer) begin
                        if (cnt == LAST) begin
                            state_nxt = S_IDLE;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + IW'(1);
                        end
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Handshake-facing outputs are flopped from the next-state decode so they
    // change cleanly on the clock edge together with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            start_q     <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_sel_q   <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            start_q     <= (state_nxt == S_START);
            out_valid_q <= (state_nxt == S_UNLOAD);
            busy_q      <= (state_nxt == S_START) || (state_nxt == S_WAIT) ||
                           (state_nxt == S_UNLOAD);
            out_sel_q   <= (state_nxt == S_UNLOAD) ? map_idx(cnt_nxt) : '0;
        end
    end

    assign start     = start_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_lea_reg_load_ctrl.sv
// Directed testbench for lea_reg_load_ctrl (NBYTES=16). Holds a model of the
// 16-byte register bank written through reg_ce/reg_din so that results read
// back through out_sel can be checked against the bytes that were loaded.
module tb_lea_reg_load_ctrl;

    localparam int NB = 16;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_data = 8'h00;
    logic [7:0]    reg_din;
    logic [NB-1:0] reg_ce;
    logic          start;
    logic          done = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [IW-1:0] out_sel;
    logic          busy;

    int n_cmp = 0;
    int n_fail = 0;

    logic [7:0] bank [NB];

    lea_reg_load_ctrl #(.NBYTES(NB), .IW(IW)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .reg_din(reg_din), .reg_ce(reg_ce), .start(start), .done(done),
        .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++)
            if (reg_ce[i]) bank[i] <= reg_din;
    end

    function automatic int mp(input int k);
`ifdef LEA_CTRL_REVERSE_EN
        return NB - 1 - k;
`else
        return k;
`endif
    endfunction

    function automatic logic [NB-1:0] ce_of(input int k);
        logic [NB-1:0] v;
        v = '0;
        v[mp(k)] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int cyc;

        // Reset state
        #2;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_out_sel", 32'(out_sel), 0);
        chk("rst_start", 32'(start), 0);
        chk("rst_reg_ce", 32'(reg_ce), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        tick();
        rst_n = 1'b1;
        tick();

        // Full load with in_valid held high; done in LOAD must be ignored
        for (int k = 0; k < NB; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(k);
            done     = (k == 3);
            #1;
            chk($sformatf("load_ce_%0d", k), 32'(reg_ce), 32'(ce_of(k)));
            chk($sformatf("load_din_%0d", k), 32'(reg_din), k);
            chk($sformatf("load_start_%0d", k), 32'(start), 0);
            tick();
        end
        in_valid = 1'b0;
        done     = 1'b1;          // done in START is ignored too
        #1;
        chk("start_pulse", 32'(start), 1);
        chk("start_busy", 32'(busy), 1);
        chk("start_in_ready", 32'(in_ready), 0);
        chk("start_ce", 32'(reg_ce), 0);
        tick();
        done = 1'b0;
        #1;
        chk("wait_start_low", 32'(start), 0);
        chk("wait_out_valid", 32'(out_valid), 0);
        chk("wait_busy", 32'(busy), 1);
        tick();
        tick();
        chk("wait_hold_out_valid", 32'(out_valid), 0);
        for (int k = 0; k < NB; k++)
            chk($sformatf("bank_%0d", k), 32'(bank[k]), k);

        done = 1'b1;
        tick();
        done = 1'b0;
        #1;
        chk("unload_first_valid", 32'(out_valid), 1);
        chk("unload_first_sel", 32'(out_sel), 32'(mp(0)));

        // Unload with a 3-cycle stall at the sixth byte
        for (int k = 0; k < NB; k++) begin
            if (k == 5) begin
                out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    #1;
                    chk($sformatf("stall_sel_%0d", s), 32'(out_sel), 32'(mp(5)));
                    chk($sformatf("stall_valid_%0d", s), 32'(out_valid), 1);
                    tick();
                end
            end
            out_ready = 1'b1;
            #1;
            chk($sformatf("unload_sel_%0d", k), 32'(out_sel), 32'(mp(k)));
            chk($sformatf("unload_data_%0d", k), 32'(bank[out_sel]), k);
            tick();
        end
        out_ready = 1'b0;
        #1;
        chk("post_unload_valid", 32'(out_valid), 0);
        chk("post_unload_busy", 32'(busy), 0);
        chk("post_unload_in_ready", 32'(in_ready), 1);
        tick();

        // Load with in_valid toggling 1,0,1,0
        n = 0;
        cyc = 0;
        while (n < NB && cyc < 64) begin
            in_valid = (cyc % 2 == 0);
            in_data  = 8'(8'h20 + n);
            #1;
            if (in_valid) begin
                chk($sformatf("gap_ce_%0d", n), 32'(reg_ce), 32'(ce_of(n)));
                n++;
            end else begin
                chk($sformatf("gap_idle_ce_%0d", n), 32'(reg_ce), 0);
            end
            tick();
            cyc++;
        end
        chk("gap_accepts", n, NB);
        in_valid = 1'b0;
        #1;
        chk("gap_start", 32'(start), 1);
        tick();

        // clear and done together in WAIT: clear wins
        clear = 1'b1;
        done  = 1'b1;
        tick();
        clear = 1'b0;
        done  = 1'b0;
        #1;
        chk("clr_wait_busy", 32'(busy), 0);
        chk("clr_wait_valid", 32'(out_valid), 0);
        chk("clr_wait_in_ready", 32'(in_ready), 1);
        tick();
        chk("clr_wait_stays_idle", 32'(out_valid), 0);

        // clear on the 7th byte drops it and restarts the count
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h40 + k);
            tick();
        end
        clear   = 1'b1;
        in_data = 8'h46;
        #1;
        chk("clr_byte_ce", 32'(reg_ce), 0);
        tick();
        clear = 1'b0;
        for (int k = 0; k < NB; k++) begin
            in_data = 8'(8'h50 + k);
            #1;
            if (k == 0) begin
                chk("clr_restart_ce", 32'(reg_ce), 32'(ce_of(0)));
                chk("clr_restart_busy", 32'(busy), 0);
            end
            tick();
        end
        in_valid = 1'b0;
        #1;
        chk("clr_load_start", 32'(start), 1);
        chk("clr_bank_first", 32'(bank[mp(0)]), 32'h50);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        #1;
        chk("pre_reset_sel", 32'(out_sel), 32'(mp(3)));

        // Asynchronous reset mid-unload
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_out_sel", 32'(out_sel), 0);
        out_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_in_ready", 32'(in_ready), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
